traffic_sensor: RTL and testbench
=================================

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

Interface
REQ-001 Parameter DEBOUNCE, default 10, cycles of stable synchronized LOOP level needed to accept a level change (legal range 1..255).
REQ-002 Parameter HOLDOFF, default 50, minimum cycles after side-road service ends before a new request may be raised (legal range 1..65535).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low; sampled on CLK rising edge.
REQ-005 LOOP  input  1  raw asynchronous side-road vehicle loop sensor, 1 = vehicle present, may bounce.
REQ-006 GRN, YLW, RED  input  1 each  main-road lights from fsm_traffic, expected one-hot.
REQ-007 CAR  output  1  registered request to fsm_traffic, level held until service observed.
REQ-008 QUEUE  output  4  vehicles waiting, saturating.
REQ-009 SERVED  output  8  vehicles released, wrap-around.
REQ-010 OVF  output  1  sticky, set when SERVED wraps.
REQ-011 FAULT  output  1  sticky, set when lights not one-hot.

Function
REQ-012 LOOP SHALL pass a 2-flop synchronizer; debounced level DEB SHALL toggle only after synchronized LOOP differs from DEB for DEBOUNCE consecutive cycles; any agreeing cycle clears the counter.
REQ-013 Arrival event SHALL be DEB 0->1; a LOOP high pulse shorter than DEBOUNCE cycles SHALL produce no arrival.
REQ-014 With FSM in IDLE, a clean LOOP rise SHALL assert CAR exactly DEBOUNCE+3 rising edges after the first edge sampling LOOP=1.
REQ-015 FSM states: IDLE, PENDING, SERVING, HOLDOFF; CAR=1 only in PENDING and only while FAULT condition absent in the current cycle.
REQ-016 IDLE: arrival -> PENDING.
REQ-017 PENDING: RED=1 (valid one-hot) -> SERVING.
REQ-018 SERVING: RED=0 -> HOLDOFF; on that edge SERVED += QUEUE (mod 256), QUEUE <= 0 plus 1 if an arrival occurs on the same edge, hold-off counter loaded with HOLDOFF-1.
REQ-019 HOLDOFF: counter decrements each cycle; at 0, QUEUE>0 (including an arrival on that edge) -> PENDING, else IDLE.
REQ-020 Every arrival in any state SHALL increment QUEUE, saturating at 15; arrivals never lost from the count below 15.
REQ-021 OVF SHALL set on the edge where the SERVED addition carries out of bit 7; cleared only by reset.
REQ-022 Lights not exactly one-hot in a cycle SHALL set FAULT next edge, force CAR=0 combinationally for that cycle, and hold FSM state.
REQ-023 All outputs registered except the CAR fault gating of REQ-022.

Reset
REQ-024 RST=0 at a rising edge SHALL, on that edge: state IDLE, CAR=0, QUEUE=0, SERVED=0, OVF=0, FAULT=0, synchronizer flops and DEB=0, debounce and hold-off counters 0; regardless of current state.
REQ-025 First arrival possible only after RST sampled 1; LOOP held high through reset release counts as one arrival after DEBOUNCE+3 edges.

Verification
REQ-026 DEBOUNCE=10: LOOP high 6 cycles then low -> CAR stays 0, QUEUE=0; LOOP high 20 cycles -> CAR=1 at edge 13, QUEUE=1.
REQ-027 Full cycle: request pending, drive RED=1 -> next edge CAR=0; two further arrivals then RED=0 -> SERVED=3, QUEUE=0, IDLE after HOLDOFF=50 cycles.
REQ-028 Arrival during HOLDOFF: QUEUE=1 -> CAR=1 exactly the cycle after hold-off counter reaches 0, not earlier.
REQ-029 Saturation/wrap: 20 arrivals before service -> QUEUE=15; preload SERVED=250 via 15-car then-served sequence -> SERVED=9, OVF=1.
REQ-030 GRN=1 and RED=1 together while PENDING -> CAR=0 that cycle, FAULT=1 next edge, state still PENDING after lights restored.
REQ-031 RST=0 asserted in SERVING with QUEUE=5 -> next edge all outputs 0, state IDLE.

Source files
------------

// File: rtl/traffic_sensor.sv
// traffic_sensor: debounced side-road loop detector that raises a service request
// to the main-road light controller and keeps queue / served statistics.
module traffic_sensor #(
    parameter int unsigned DEBOUNCE = 10,
    parameter int unsigned HOLDOFF  = 50
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOOP,
    input  logic       GRN,
    input  logic       YLW,
    input  logic       RED,
    output logic       CAR,
    output logic [3:0] QUEUE,
    output logic [7:0] SERVED,
    output logic       OVF,
    output logic       FAULT
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_SERVING = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_deb;
    logic        r_deb_d;
    logic [7:0]  r_dcnt;
    logic [1:0]  r_state;
    logic [15:0] r_hcnt;
    logic [3:0]  r_queue;
    logic [7:0]  r_served;
    logic        r_ovf;
    logic        r_fault;
    logic        r_car;

    logic        w_lights_ok;
    logic        w_arrival;
    logic [3:0]  w_q_inc;
    logic [3:0]  w_queue_nxt;
    logic [1:0]  w_state_nxt;
    logic [15:0] w_hcnt_nxt;
    logic [8:0]  w_sum;

    // Exactly one lamp lit: odd number of ones and not all three.
    assign w_lights_ok = (GRN ^ YLW ^ RED) & ~(GRN & YLW & RED);
    assign w_arrival   = r_deb & ~r_deb_d;
    assign w_q_inc     = (r_queue == 4'd15) ? 4'd15 : r_queue + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_queue_nxt = w_arrival ? w_q_inc : r_queue;
        w_sum       = {1'b0, r_served};
        if (w_lights_ok) begin
            case (r_state)
                S_IDLE: begin
                    if (w_arrival || (r_queue != 4'd0)) w_state_nxt = S_PENDING;
                end
                S_PENDING: begin
                    if (RED) w_state_nxt = S_SERVING;
                end
                S_SERVING: begin
                    if (!RED) begin
                        w_state_nxt = S_HOLDOFF;
                        w_hcnt_nxt  = HOLD_LOAD;
                        w_sum       = {1'b0, r_served} + {5'b0, r_queue};
                        w_queue_nxt = {3'b0, w_arrival};
                    end
                end
                default: begin
                    if (r_hcnt == 16'd0) begin
                        w_state_nxt = (w_queue_nxt != 4'd0) ? S_PENDING : S_IDLE;
                    end else begin
                        w_hcnt_nxt = r_hcnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_deb    <= 1'b0;
            r_deb_d  <= 1'b0;
            r_dcnt   <= '0;
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_queue  <= '0;
            r_served <= '0;
            r_ovf    <= 1'b0;
            r_fault  <= 1'b0;
            r_car    <= 1'b0;
        end else begin
            r_sync1 <= LOOP;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 != r_deb) begin
                if (r_dcnt == DEB_LAST) begin
                    r_deb  <= r_sync2;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 8'd1;
                end
            end else begin
                r_dcnt <= '0;
            end
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_queue  <= w_queue_nxt;
            r_served <= w_sum[7:0];
            r_ovf    <= r_ovf | w_sum[8];
            r_fault  <= r_fault | ~w_lights_ok;
            r_car    <= (w_state_nxt == S_PENDING);
        end
    end

    // Request is dropped in the same cycle the lamps go invalid.
    assign CAR    = r_car & w_lights_ok;
    assign QUEUE  = r_queue;
    assign SERVED = r_served;
    assign OVF    = r_ovf;
    assign FAULT  = r_fault;

endmodule

// File: tb/tb_traffic_sensor.sv
// tb_traffic_sensor: directed + randomized checks of traffic_sensor against an
// event-level behavioural model.
module tb_traffic_sensor;

    localparam int DEB  = 10;
    localparam int HOLD = 50;

    localparam int P_IDLE = 0;
    localparam int P_PEND = 1;
    localparam int P_SERV = 2;
    localparam int P_HOLD = 3;

    logic       CLK;
    logic       RST;
    logic       LOOP;
    logic       GRN;
    logic       YLW;
    logic       RED;
    logic       CAR;
    logic [3:0] QUEUE;
    logic [7:0] SERVED;
    logic       OVF;
    logic       FAULT;

    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model state
    bit m_lq[$];
    bit m_win[$];
    bit m_deb, m_deb_prev;
    int m_phase, m_cyc, m_release;
    int m_queue, m_served;
    bit m_ovf, m_fault;

    traffic_sensor #(.DEBOUNCE(DEB), .HOLDOFF(HOLD)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .LOOP   (LOOP),
        .GRN    (GRN),
        .YLW    (YLW),
        .RED    (RED),
        .CAR    (CAR),
        .QUEUE  (QUEUE),
        .SERVED (SERVED),
        .OVF    (OVF),
        .FAULT  (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lights_ok();
        return (int'(GRN) + int'(YLW) + int'(RED)) == 1;
    endfunction

    // One rising edge of the reference: vehicles arrive when the synchronized
    // loop has disagreed with the accepted level for DEB consecutive samples.
    task automatic model_edge();
        bit ok, arr, s2, nd;
        int qa;
        m_cyc++;
        if (!RST) begin
            m_lq.delete();
            m_win.delete();
            m_deb = 0; m_deb_prev = 0;
            m_phase = P_IDLE; m_release = 0;
            m_queue = 0; m_served = 0; m_ovf = 0; m_fault = 0;
        end else begin
            ok  = lights_ok();
            arr = m_deb && !m_deb_prev;
            s2  = (m_lq.size() >= 2) ? m_lq[m_lq.size()-2] : 1'b0;
            qa  = arr ? ((m_queue < 15) ? m_queue + 1 : 15) : m_queue;
            nd  = m_deb;
            if (s2 != m_deb) begin
                m_win.push_back(s2);
                if (m_win.size() == DEB) begin
                    nd = s2;
                    m_win.delete();
                end
            end else begin
                m_win.delete();
            end
            if (!ok) begin
                if (m_phase == P_HOLD) m_release++;
            end else begin
                case (m_phase)
                    P_IDLE: if (qa > 0) m_phase = P_PEND;
                    P_PEND: if (RED) m_phase = P_SERV;
                    P_SERV: if (!RED) begin
                        m_served += m_queue;
                        if (m_served > 255) begin
                            m_served -= 256;
                            m_ovf = 1;
                        end
                        qa = arr ? 1 : 0;
                        m_phase = P_HOLD;
                        m_release = m_cyc + HOLD;
                    end
                    default: if (m_cyc == m_release) m_phase = (qa > 0) ? P_PEND : P_IDLE;
                endcase
            end
            m_queue = qa;
            if (!ok) m_fault = 1;
            m_deb_prev = m_deb;
            m_deb = nd;
            m_lq.push_back(LOOP);
            if (m_lq.size() > 2) void'(m_lq.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("CAR",    {7'b0, CAR},   ((m_phase == P_PEND) && lights_ok()) ? 8'd1 : 8'd0);
        chk("QUEUE",  {4'b0, QUEUE}, 8'(m_queue));
        chk("SERVED", SERVED,        8'(m_served));
        chk("OVF",    {7'b0, OVF},   {7'b0, m_ovf});
        chk("FAULT",  {7'b0, FAULT}, {7'b0, m_fault});
    endtask

    task automatic set_lights(input int w);
        GRN = (w == 0);
        YLW = (w == 1);
        RED = (w == 2);
    endtask

    // One vehicle, optionally preceded by a bounce too short to be accepted.
    task automatic arrive();
        int g;
        g = int'($urandom_range(0, DEB - 1));
        if (g > 0) begin
            LOOP = 1'b1; repeat (g) tick();
            LOOP = 1'b0; repeat (2) tick();
        end
        LOOP = 1'b1; repeat (DEB + 3) tick();
        LOOP = 1'b0; repeat (DEB + 3) tick();
    endtask

    task automatic serve();
        set_lights(2); repeat (2) tick();
        set_lights(0); tick();
    endtask

    task automatic flush();
        LOOP = 1'b0;
        set_lights(0);
        repeat (2 * DEB + 6) tick();
        repeat (2) begin
            serve();
            repeat (HOLD + 2) tick();
        end
        chk("FLUSH_QUEUE", {4'b0, QUEUE}, 8'd0);
    endtask

    initial begin
        int e, n, guard;
        RST = 1'b0; LOOP = 1'b0;
        set_lights(0);

        repeat (3) tick();
        chk("RST_CAR", {7'b0, CAR}, 8'd0);
        chk("RST_QUEUE", {4'b0, QUEUE}, 8'd0);
        chk("RST_SERVED", SERVED, 8'd0);
        chk("RST_FAULT", {7'b0, FAULT}, 8'd0);
        RST = 1'b1;
        repeat (3) tick();

        // short pulse is rejected
        LOOP = 1'b1; repeat (6) tick();
        LOOP = 1'b0; repeat (20) tick();
        chk("SHORT_CAR", {7'b0, CAR}, 8'd0);
        chk("SHORT_QUEUE", {4'b0, QUEUE}, 8'd0);

        // clean rise: request exactly DEB+3 edges later
        LOOP = 1'b1;
        for (int k = 1; k <= DEB + 3; k++) begin
            tick();
            chk("EDGE_CAR", {7'b0, CAR}, (k == DEB + 3) ? 8'd1 : 8'd0);
        end
        repeat (7) tick();
        chk("LONG_QUEUE", {4'b0, QUEUE}, 8'd1);
        LOOP = 1'b0; repeat (DEB + 3) tick();

        // full service cycle with two extra arrivals
        set_lights(2); tick();
        chk("SERV_CAR", {7'b0, CAR}, 8'd0);
        arrive(); arrive();
        set_lights(0); tick();
        chk("FULL_SERVED", SERVED, 8'd3);
        chk("FULL_QUEUE", {4'b0, QUEUE}, 8'd0);
        repeat (HOLD + 2) tick();
        chk("FULL_IDLE_CAR", {7'b0, CAR}, 8'd0);

        // arrival during hold-off
        arrive();
        serve();
        e = m_cyc;
        arrive();
        while (m_cyc < e + HOLD) begin
            tick();
            chk("HOLD_CAR", {7'b0, CAR}, (m_cyc == e + HOLD) ? 8'd1 : 8'd0);
        end
        chk("HOLD_QUEUE", {4'b0, QUEUE}, 8'd1);
        serve();

        // randomized loop activity under valid light sequences
        repeat (20) begin
            set_lights(int'($urandom_range(0, 2)));
            n = int'($urandom_range(3, 60));
            repeat (n) begin
                if ($urandom_range(0, 7) == 0) LOOP = ~LOOP;
                tick();
            end
        end
        flush();

        // saturation
        repeat (20) arrive();
        chk("SAT_QUEUE", {4'b0, QUEUE}, 8'd15);
        serve();
        repeat (HOLD + 2) tick();

        // wrap of SERVED
        guard = 0;
        while (m_served != 250 && guard < 40) begin
            n = (250 - m_served + 256) % 256;
            if (n > 15) n = 15;
            repeat (n) arrive();
            serve();
            repeat (HOLD + 2) tick();
            guard++;
        end
        chk("PRE_SERVED", SERVED, 8'd250);
        repeat (15) arrive();
        serve();
        chk("WRAP_SERVED", SERVED, 8'd9);
        chk("WRAP_OVF", {7'b0, OVF}, 8'd1);
        repeat (HOLD + 2) tick();

        // lamp fault while pending
        arrive();
        chk("FLT_PEND_CAR", {7'b0, CAR}, 8'd1);
        GRN = 1'b1; RED = 1'b1;
        #1;
        chk("FLT_GATE_CAR", {7'b0, CAR}, 8'd0);
        chk("FLT_PRE", {7'b0, FAULT}, 8'd0);
        tick();
        chk("FLT_SET", {7'b0, FAULT}, 8'd1);
        set_lights(0);
        #1;
        chk("FLT_RESTORE_CAR", {7'b0, CAR}, 8'd1);
        tick();
        chk("FLT_STILL_PEND", {7'b0, CAR}, 8'd1);

        // reset while serving five vehicles
        guard = 0;
        while (m_queue < 5 && guard < 10) begin
            arrive();
            guard++;
        end
        chk("RS_QUEUE", {4'b0, QUEUE}, 8'd5);
        set_lights(2); repeat (2) tick();
        RST = 1'b0; LOOP = 1'b1;
        tick();
        chk("RS_CAR", {7'b0, CAR}, 8'd0);
        chk("RS_QUEUE0", {4'b0, QUEUE}, 8'd0);
        chk("RS_SERVED", SERVED, 8'd0);
        chk("RS_OVF", {7'b0, OVF}, 8'd0);
        chk("RS_FAULT", {7'b0, FAULT}, 8'd0);
        tick();

        // loop held high through reset release
        RST = 1'b1;
        set_lights(0);
        for (int k = 1; k <= DEB + 3; k++) begin
            tick();
            chk("REL_CAR", {7'b0, CAR}, (k == DEB + 3) ? 8'd1 : 8'd0);
        end
        chk("REL_QUEUE", {4'b0, QUEUE}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
